tc_intlv_addr_gen: RTL

Turbo-interleaver address generator, directly downstream of the PB-size encoder. It latches the interleaver length L (64, 544 or 2080) on a start pulse. It then streams L address pairs: the natural index i and the permuted index π(i) = (STRIDE·i) mod L. The pairs go to the interleaver RAM read/write stage over a valid/ready handshake. The permutation is computed incrementally, with no multiplier and no lookup table.

---
 rtl/tc_intlv_addr_gen_if.sv | 25 ++
 rtl/tc_intlv_addr_gen.sv | 105 ++++++++++
 2 files changed

// File: rtl/tc_intlv_addr_gen_if.sv
// Address-pair stream from the interleaver address generator to the RAM stage.
// The generator holds the pair stable until ready is seen with valid.
interface tc_intlv_addr_gen_if;
   logic [11:0] addr_seq;
   logic [11:0] addr_int;
   logic        valid;
   logic        last;
   logic        ready;

   modport master (
      output addr_seq,
      output addr_int,
      output valid,
      output last,
      input  ready
   );

   modport slave (
      input  addr_seq,
      input  addr_int,
      input  valid,
      input  last,
      output ready
   );
endinterface

// File: rtl/tc_intlv_addr_gen.sv
// Turbo-interleaver address generator: streams (i, STRIDE*i mod L) for a latched
// length L, updating the permuted index incrementally.
module tc_intlv_addr_gen #(
   parameter int unsigned STRIDE = 31
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic [11:0]                len_l,
   input  logic                       start,
   tc_intlv_addr_gen_if.master        bus,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] len_q, len_d;
   logic [11:0] i_q, i_d;
   logic [11:0] pi_q, pi_d;
   logic        err_q, err_d;

   logic        len_ok;
   logic        at_end;
   logic        xfer;
   logic [12:0] pi_sum;
   logic [11:0] pi_wrap;

   assign len_ok = (len_l == 12'h040) || (len_l == 12'h220) || (len_l == 12'h820);
   assign at_end = (i_q == (len_q - 12'd1));
   assign xfer   = (state_q == RUN) && bus.ready;

   // STRIDE < L, so one conditional subtract keeps pi in [0, L)
   assign pi_sum  = {1'b0, pi_q} + 13'(STRIDE);
   assign pi_wrap = 12'(pi_sum - {1'b0, len_q});

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      i_d     = i_q;
      pi_d    = pi_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len_ok) begin
                  len_d   = len_l;
                  i_d     = '0;
                  pi_d    = '0;
                  state_d = RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (xfer) begin
               if (at_end) begin
                  state_d = DONE;
               end else begin
                  i_d  = i_q + 12'd1;
                  pi_d = (pi_sum >= {1'b0, len_q}) ? pi_wrap : pi_sum[11:0];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         i_q     <= '0;
         pi_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         i_q     <= i_d;
         pi_q    <= pi_d;
         err_q   <= err_d;
      end
   end

   // All outputs decode registered state only; nothing combinational from ready/start
   assign bus.addr_seq = i_q;
   assign bus.addr_int = pi_q;
   assign bus.valid    = (state_q == RUN);
   assign bus.last     = (state_q == RUN) && at_end;
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign err          = err_q;

endmodule
